// File: rtl/adc_valid_strobe_mc.sv
// Multi-channel ADC-valid strobe generator: synchronises each valid level, detects
// the selected edge, decimates events and captures the ADC word on every kept event.
module adc_valid_strobe_mc #(
   parameter int N_CH        = 2,
   parameter int DATA_W      = 12,
   parameter int SYNC_STAGES = 2,
   parameter int DECIM_W     = 4,
   parameter int STUCK_W     = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_CH-1:0]          valid_adc,
   input  logic [N_CH*DATA_W-1:0]   data_adc,
   input  logic [1:0]               mode,
   input  logic [DECIM_W-1:0]       decim,
   input  logic [STUCK_W-1:0]       stuck_limit,
   input  logic                     clr_err,
   output logic [N_CH-1:0]          ready_adc,
   output logic [N_CH*DATA_W-1:0]   sample_data,
   output logic [N_CH-1:0]          stuck_err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HIGH  = 2'd1,
      ST_STUCK = 2'd2
   } state_t;

   // Mode 11 falls back to rising-only, so only 01 suppresses rising events.
   logic               rise_en;
   logic               fall_en;
   logic               wdog_en;
   logic [STUCK_W-1:0] limit_m1;

   assign rise_en  = (mode != 2'b01);
   assign fall_en  = (mode == 2'b01) || (mode == 2'b10);
   assign wdog_en  = (stuck_limit != '0);
   assign limit_m1 = stuck_limit - STUCK_W'(1);

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   valid_s;
      state_t                 state_q, state_d;
      logic [STUCK_W-1:0]     hcnt_q, hcnt_d;
      logic [DECIM_W-1:0]     dcnt_q, dcnt_d;
      logic                   ready_q, ready_d;
      logic                   err_q, err_d;
      logic [DATA_W-1:0]      data_q, data_d;
      logic                   rise_ev, fall_ev, stuck_ev, qual_ev;

      assign valid_s = sync_q[SYNC_STAGES-1];

      always_comb begin
         state_d  = state_q;
         hcnt_d   = hcnt_q;
         dcnt_d   = dcnt_q;
         data_d   = data_q;
         ready_d  = 1'b0;
         rise_ev  = 1'b0;
         fall_ev  = 1'b0;
         stuck_ev = 1'b0;

         case (state_q)
            ST_IDLE: begin
               if (valid_s) begin
                  state_d = ST_HIGH;
                  hcnt_d  = '0;
                  rise_ev = 1'b1;
               end
            end
            ST_HIGH: begin
               // A falling level takes priority over a watchdog expiry in the same cycle.
               if (!valid_s) begin
                  state_d = ST_IDLE;
                  fall_ev = 1'b1;
               end else if (wdog_en && (hcnt_q == limit_m1)) begin
                  state_d  = ST_STUCK;
                  stuck_ev = 1'b1;
               end else begin
                  hcnt_d = hcnt_q + STUCK_W'(1);
               end
            end
            ST_STUCK: begin
               if (!valid_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase

         qual_ev = (rise_ev && rise_en) || (fall_ev && fall_en);

         // >= lets a lowered ratio take effect on the very next event.
         if (qual_ev) begin
            if (dcnt_q >= decim) begin
               ready_d = 1'b1;
               dcnt_d  = '0;
               data_d  = data_adc[c*DATA_W +: DATA_W];
            end else begin
               dcnt_d = dcnt_q + DECIM_W'(1);
            end
         end

         if (stuck_ev)     err_d = 1'b1;
         else if (clr_err) err_d = 1'b0;
         else              err_d = err_q;
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            sync_q  <= '0;
            state_q <= ST_IDLE;
            hcnt_q  <= '0;
            dcnt_q  <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
         end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], valid_adc[c]};
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            dcnt_q  <= dcnt_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            data_q  <= data_d;
         end
      end

      assign ready_adc[c]                     = ready_q;
      assign stuck_err[c]                     = err_q;
      assign sample_data[c*DATA_W +: DATA_W]  = data_q;
   end

endmodule

// File: tb/tb_adc_valid_strobe_mc.sv
// Directed bench for adc_valid_strobe_mc: latency, edge modes, decimation,
// stuck watchdog, simultaneous channels and mid-run reset.
module tb_adc_valid_strobe_mc;
   localparam int N_CH    = 2;
   localparam int DATA_W  = 12;
   localparam int DECIM_W = 4;
   localparam int STUCK_W = 8;

   logic                    clk = 1'b0;
   logic                    reset;
   logic [N_CH-1:0]         valid_adc;
   logic [N_CH*DATA_W-1:0]  data_adc;
   logic [1:0]              mode;
   logic [DECIM_W-1:0]      decim;
   logic [STUCK_W-1:0]      stuck_limit;
   logic                    clr_err;
   logic [N_CH-1:0]         ready_adc;
   logic [N_CH*DATA_W-1:0]  sample_data;
   logic [N_CH-1:0]         stuck_err;

   int n_checks = 0;
   int n_pass   = 0;

   adc_valid_strobe_mc #(
      .N_CH(N_CH), .DATA_W(DATA_W), .SYNC_STAGES(2), .DECIM_W(DECIM_W), .STUCK_W(STUCK_W)
   ) dut (
      .clk(clk), .reset(reset), .valid_adc(valid_adc), .data_adc(data_adc),
      .mode(mode), .decim(decim), .stuck_limit(stuck_limit), .clr_err(clr_err),
      .ready_adc(ready_adc), .sample_data(sample_data), .stuck_err(stuck_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // One active edge, then return at the following falling edge for sampling/driving.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin
      logic [39:0] mask2, exp2;
      logic [27:0] mask3, exp3;
      logic [25:0] mask6, exp6;
      int          cnt2;
      logic        other;

      reset = 1'b1; valid_adc = '0; data_adc = '0; mode = 2'b00;
      decim = '0; stuck_limit = '0; clr_err = 1'b0;
      step(); step();
      chk("rst_ready", ready_adc, 0);
      chk("rst_sample", sample_data, 0);
      chk("rst_err", stuck_err, 0);
      reset = 1'b0;
      step();

      // Basic latency: strobe after the third edge.
      valid_adc = 2'b01;
      data_adc  = {12'h000, 12'h5A3};
      step(); chk("t1_e0", ready_adc, 0);
      step(); chk("t1_e1", ready_adc, 0);
      step(); chk("t1_e2", ready_adc, 2'b01);
      chk("t1_sample", sample_data, {12'h000, 12'h5A3});
      step(); chk("t1_e3", ready_adc, 0);
      valid_adc = 2'b00;
      repeat (6) step();

      // Both edges, keep one in three: 6 pulses on ch1.
      mode = 2'b10; decim = 4'd2; data_adc[23:12] = 12'hABC;
      mask2 = '0; cnt2 = 0; other = 1'b0;
      for (int k = 0; k < 40; k++) begin
         valid_adc[1] = (k < 36) && ((k % 6) < 3);
         step();
         if (ready_adc[1]) begin mask2[k] = 1'b1; cnt2++; end
         if (ready_adc[0]) other = 1'b1;
      end
      exp2 = '0; exp2[8] = 1'b1; exp2[17] = 1'b1; exp2[26] = 1'b1; exp2[35] = 1'b1;
      chk("t2_mask", mask2, exp2);
      chk("t2_count", cnt2, 4);
      chk("t2_ch0_silent", other, 0);
      chk("t2_sample1", sample_data[23:12], 12'hABC);

      // Stuck watchdog with clear during the high period.
      decim = '0; stuck_limit = 8'd5; mask3 = '0;
      for (int k = 0; k < 28; k++) begin
         valid_adc[0] = (k < 20);
         clr_err      = (k == 11);
         step();
         if (ready_adc[0]) mask3[k] = 1'b1;
         if (k == 6)  chk("t3_err_before", stuck_err[0], 0);
         if (k == 7)  chk("t3_err_set", stuck_err[0], 1);
         if (k == 11) chk("t3_err_clr", stuck_err[0], 0);
         if (k == 27) chk("t3_err_stays_clr", stuck_err[0], 0);
      end
      clr_err = 1'b0;
      exp3 = '0; exp3[2] = 1'b1;
      chk("t3_mask", mask3, exp3);

      // clr_err coinciding with stuck detection.
      for (int k = 0; k < 16; k++) begin
         valid_adc[0] = (k < 12);
         clr_err      = (k == 7);
         step();
         if (k == 7) chk("t4_set_wins", stuck_err[0], 1);
         if (k == 8) chk("t4_still_set", stuck_err[0], 1);
      end
      clr_err = 1'b0; stuck_limit = '0;

      // Simultaneous rise on both channels.
      mode = 2'b00; data_adc = {12'h9F0, 12'h123};
      valid_adc = 2'b11;
      step();
      step(); chk("t5_e1", ready_adc, 0);
      step(); chk("t5_e2", ready_adc, 2'b11);
      chk("t5_sample", sample_data, {12'h9F0, 12'h123});
      step(); chk("t5_e3", ready_adc, 0);
      chk("t5_err_sticky", stuck_err, 2'b01);
      valid_adc = 2'b00;
      repeat (6) step();

      // Reset with a pending strobe and dcnt=1.
      decim = 4'd1; data_adc = {12'h000, 12'h777};
      mask6 = '0; other = 1'b0;
      for (int j = 0; j < 26; j++) begin
         valid_adc[0] = (j < 4) || ((j >= 8) && (j < 16)) || (j >= 20);
         reset        = (j == 9) || (j == 10);
         step();
         if (ready_adc[0]) mask6[j] = 1'b1;
         if (ready_adc[1]) other = 1'b1;
         if (j == 10) begin
            chk("t6_rst_ready", ready_adc, 0);
            chk("t6_rst_sample", sample_data, 0);
            chk("t6_rst_err", stuck_err, 0);
         end
      end
      exp6 = '0; exp6[22] = 1'b1;
      chk("t6_mask", mask6, exp6);
      chk("t6_ch1_silent", other, 0);
      chk("t6_sample", sample_data[11:0], 12'h777);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
